// File: rtl/demux_dispatcher.sv
// 1:4 demux dispatcher: steers a valid/ready input stream into four one-entry
// channel holding registers, using either round-robin or per-beat destination.
//
// state | meaning
// IDLE  | not accepting; waits for en
// RUN   | accepting beats into the target channel
// DRAIN | en dropped with beats still held; consumers empty the channels
module demux_dispatcher #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  mode,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     in_data,
    input  logic [1:0]            in_dest,
    output logic [3:0]            out_valid,
    input  logic [3:0]            out_ready,
    output logic [4*DATA_W-1:0]   out_data,
    output logic [1:0]            sel,
    output logic                  busy,
    output logic [CNT_W-1:0]      beat_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t     state;
    logic [1:0] rr_ptr;
    logic [1:0] tgt;
    logic       accept;

    // Target channel and handshake; a full channel may take a new beat when its
    // consumer empties it in the same cycle, so there is no bubble.
    always_comb begin
        tgt      = mode ? in_dest : rr_ptr;
        in_ready = (state == RUN) && (!out_valid[tgt] || out_ready[tgt]);
        accept   = in_valid && in_ready;
    end

    assign busy = (state != IDLE);

    // Control FSM plus steering select, rotation pointer and beat counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            rr_ptr   <= 2'd0;
            sel      <= 2'd0;
            beat_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (en) state <= RUN;
                end
                RUN: begin
                    if (!en) state <= (|out_valid) ? DRAIN : IDLE;
                end
                DRAIN: begin
                    if (en)              state <= RUN;
                    else if (~|out_valid) state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            if (accept) begin
                sel      <= tgt;
                beat_cnt <= beat_cnt + 1'b1;
                // Directed traffic leaves the rotation where it was.
                if (!mode) rr_ptr <= rr_ptr + 2'd1;
            end
        end
    end

    // Channel holding registers: load on accept, clear valid on drain; data is
    // left in place after a drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 4'b0000;
            out_data  <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (accept && (tgt == 2'(i))) begin
                    out_valid[i]                 <= 1'b1;
                    out_data[i*DATA_W +: DATA_W] <= in_data;
                end else if (out_valid[i] && out_ready[i]) begin
                    out_valid[i] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: doc/demux_dispatcher.md
Name: demux_dispatcher

Overview:
- Sequencing controller for the team's 1:4 demux datapath: accepts a valid/ready input stream and steers each beat to one of four output channels.
- Each channel has a one-entry holding register with its own valid/ready handshake.
- Destination comes from a round-robin pointer (mode 0) or from a per-beat destination field (mode 1).
- Sits between a single producer and four consumers; also exports the steering select and an accepted-beat count.

Parameters:
DATA_W, 8, width of each data beat
CNT_W, 16, width of accepted-beat counter (wraps)

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
en  input  1  dispatcher enable
mode  input  1  0 = round-robin, 1 = directed by in_dest
in_valid  input  1  producer beat valid
in_ready  output  1  dispatcher can accept beat this cycle
in_data  input  DATA_W  producer beat data
in_dest  input  2  destination channel (used in mode 1 only)
out_valid  output  4  per-channel holding register full
out_ready  input  4  per-channel consumer ready
out_data  output  4*DATA_W  channel i data at bits [i*DATA_W +: DATA_W]
sel  output  2  channel of most recently accepted beat
busy  output  1  state != IDLE
beat_cnt  output  CNT_W  total accepted beats

Behaviour:
- Reset (async, rst_n=0):
  - out_valid=0, out_data=0, sel=0, beat_cnt=0.
  - rr pointer=0, state=IDLE.
  - Outputs take these values immediately, not at the next clock edge.
- States:
  - IDLE: in_ready=0. Go to RUN when en=1.
  - RUN: accepts beats. When en=0, go to DRAIN if any out_valid bit is set, else go to IDLE.
  - DRAIN: in_ready=0 and the outputs keep draining. Go to IDLE when out_valid==0. If en returns to 1 while in DRAIN, go to RUN.
- Target channel t = mode ? in_dest : rr_ptr. This is combinational and sampled per beat.
- in_ready = (state==RUN) && (!out_valid[t] || out_ready[t]).
  - This is a combinational path from out_ready/mode/in_dest to in_ready, and it is permitted.
- Accept = in_valid && in_ready. On accept, at the next edge:
  - out_data[t] <= in_data and out_valid[t] <= 1.
  - sel <= t.
  - beat_cnt <= beat_cnt+1, wrapping at 2^CNT_W.
  - rr_ptr <= rr_ptr+1 (mod 4) in mode 0 only.
- Latency: 1 cycle from accept to out_valid.
- Throughput: 1 beat/cycle when the target consumer is ready.
- Channel drain: out_valid[i] clears when out_valid[i] && out_ready[i] and there is no simultaneous accept into channel i.
  - Simultaneous drain and accept on the same channel keeps out_valid[i]=1 and loads the new data (pass-through, no bubble).
- Full channel: if the target is full and its consumer is not ready, in_ready=0. No reordering to other channels.
  - In mode 0, the pointer waits on the blocked channel (strict rotation).
- rr_ptr is unchanged by mode 1 traffic. Switching mode does not reset rr_ptr.
- out_data[i] holds its value while out_valid[i]=0. Contents are not cleared after drain.
- Channels not targeted are unaffected by in_data changes.
- Reset mid-operation discards any held beats and returns immediately to the reset values.

Test Plan:
- Reset/idle: rst_n=0, then 1 with en=0 and in_valid=1 -> in_ready=0, out_valid=0000, beat_cnt=0, busy=0.
- Round-robin streaming: en=1, mode=0, out_ready=1111, beats 0xA0..0xA7 on consecutive cycles -> one accept per cycle; out_valid one-hot pattern 0001,0010,0100,1000 repeating one cycle after each accept; sel sequence 0,1,2,3,0,1,2,3; beat_cnt=8.
- Directed with backpressure: mode=1, out_ready=0000, beats 0x11 to dest 2 then 0x22 to dest 2 -> first accepted, out_valid=0100, out_data[2]=0x11. Second stalls with in_ready=0 until out_ready[2]=1, then pass-through same cycle: out_data[2]=0x22, out_valid stays 0100.
- Round-robin blocking: mode=0, out_ready=1101, 4 beats -> channel 1 fills. The next beat targeting channel 1 stalls with in_ready=0 until out_ready[1]=1; rr_ptr does not skip channel 1.
- Drain on disable: fill channels 0 and 3 with out_ready=0, drop en -> busy=1 in DRAIN and in_ready=0. Raise out_ready=1001 -> out_valid=0000 next cycle, IDLE one cycle later, busy=0.
- Async reset mid-stream: assert rst_n=0 between clock edges with out_valid=1010 -> out_valid=0000, sel=0, beat_cnt=0 without waiting for the clock edge.
